// File: rtl/source_out_ser.sv
// Purpose : serialise a WIDTH-bit word MSB-first over LANES lanes, with a frame enable and a programmable-delay copy of it.
// Latency : the first beat of a word accepted at edge N is on data_out from edge N; a frame lasts WIDTH/LANES cycles.
// Backpress: ready is low while a frame is in flight (except on its last beat); words offered while ready=0 are dropped.
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   out_en             gates acceptance of new words; a running frame always completes
//   data_en_in/data_in input word valid and parallel word; ready says it is taken this cycle
//   dly_sel            delay of data_en_dly relative to data_en (clamped to MAX_DLY)
//   data_en, data_out  registered frame enable and the current beat (zero when idle)
//   data_en_dly        data_en delayed by dly_sel cycles
//   frame_done         one-cycle pulse on the last beat of each frame
module source_out_ser #(
    parameter int WIDTH   = 8,
    parameter int LANES   = 1,
    parameter int MAX_DLY = 8,
    parameter int DLY_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               out_en,
    input  logic               data_en_in,
    input  logic [WIDTH-1:0]   data_in,
    output logic               ready,
    input  logic [DLY_W-1:0]   dly_sel,
    output logic               data_en,
    output logic               data_en_dly,
    output logic [LANES-1:0]   data_out,
    output logic               frame_done
);

    localparam int BEATS = WIDTH / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BEATS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]         state;
    logic [WIDTH-1:0]   shift_reg;
    logic [CNT_W-1:0]   beat_cnt;
    logic [MAX_DLY-1:0] en_taps;
    logic               last_beat;
    logic               accept;
    logic [DLY_W-1:0]   dly_clamp;

    // beat_cnt counts the beats still to come after the current one; it is
    // also zero in IDLE, so last_beat alone qualifies frame_done via data_en.
    assign last_beat = (beat_cnt == '0);

    // Held low during reset so an upstream source cannot see a false accept.
    assign ready  = rst_n & out_en & ((state == ST_IDLE) | last_beat);
    assign accept = data_en_in & ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shift_reg <= data_in;
                        beat_cnt  <= CNT_LOAD;
                        state     <= ST_SHIFT;
                    end
                end
                default: begin
                    if (!last_beat) begin
                        shift_reg <= shift_reg << LANES;
                        beat_cnt  <= beat_cnt - CNT_W'(1);
                    end else if (accept) begin
                        // Reload on the last beat: next frame follows with no gap.
                        shift_reg <= data_in;
                        beat_cnt  <= CNT_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign data_en    = (state == ST_SHIFT);
    assign frame_done = data_en & last_beat;
    assign data_out   = data_en ? shift_reg[WIDTH-1 -: LANES] : '0;

    // en_taps[i] is data_en delayed by i+1 cycles; it keeps running while idle
    // so trailing enables drain out after the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_taps <= '0;
        end else begin
            en_taps[0] <= data_en;
            for (int i = 1; i < MAX_DLY; i++) begin
                en_taps[i] <= en_taps[i-1];
            end
        end
    end

    // Compare-and-select rather than a variable index keeps the selector
    // width independent of MAX_DLY.
    always_comb begin
        dly_clamp   = (dly_sel > DLY_W'(MAX_DLY)) ? DLY_W'(MAX_DLY) : dly_sel;
        data_en_dly = data_en;
        for (int i = 0; i < MAX_DLY; i++) begin
            if (dly_clamp == DLY_W'(i + 1)) begin
                data_en_dly = en_taps[i];
            end
        end
    end

endmodule

// File: tb/tb_source_out_ser.sv
// Purpose : exercises three source_out_ser instances (8x1, 8x2, 4x4 lanes) driven in lockstep.
// Latency : outputs are sampled 1 time unit after each rising edge; ready also just before it.
// Backpress: words are offered regardless of ready; the reference model decides which are taken.
module tb_source_out_ser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       out_en;
    logic       data_en_in;
    logic [7:0] word;
    logic [3:0] dly_sel;

    logic       r1, en1, dl1, fd1;
    logic [0:0] do1;
    logic       r2, en2, dl2, fd2;
    logic [1:0] do2;
    logic       r4, en4, dl4, fd4;
    logic [3:0] do4;

    always #5 clk = ~clk;

    source_out_ser #(.WIDTH(8), .LANES(1), .MAX_DLY(8), .DLY_W(4)) u_l1 (
        .clk(clk), .rst_n(rst_n), .out_en(out_en), .data_en_in(data_en_in),
        .data_in(word), .ready(r1), .dly_sel(dly_sel), .data_en(en1),
        .data_en_dly(dl1), .data_out(do1), .frame_done(fd1));

    source_out_ser #(.WIDTH(8), .LANES(2), .MAX_DLY(8), .DLY_W(4)) u_l2 (
        .clk(clk), .rst_n(rst_n), .out_en(out_en), .data_en_in(data_en_in),
        .data_in(word), .ready(r2), .dly_sel(dly_sel), .data_en(en2),
        .data_en_dly(dl2), .data_out(do2), .frame_done(fd2));

    source_out_ser #(.WIDTH(4), .LANES(4), .MAX_DLY(8), .DLY_W(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .out_en(out_en), .data_en_in(data_en_in),
        .data_in(word[3:0]), .ready(r4), .dly_sel(dly_sel), .data_en(en4),
        .data_en_dly(dl4), .data_out(do4), .frame_done(fd4));

    int total = 0;
    int bad   = 0;

    // Reference model: per instance, a queue of beats still to be shown
    // (front = beat on the wires now, bit 8 marks the last beat of a frame)
    // and a history of data_en (index 0 = now, index d = d cycles ago).
    int W[3] = '{8, 8, 4};
    int L[3] = '{1, 2, 4};
    int q[3][$];
    int hist[3][$];
    bit exp_pr[3];

    logic       o_rdy[3], o_en[3], o_dly[3], o_fd[3], p_rdy[3];
    logic [3:0] o_dat[3];

    task automatic sample(output logic rd[3]);
        rd[0] = r1; rd[1] = r2; rd[2] = r4;
        o_en[0]  = en1; o_en[1]  = en2; o_en[2]  = en4;
        o_dly[0] = dl1; o_dly[1] = dl2; o_dly[2] = dl4;
        o_fd[0]  = fd1; o_fd[1]  = fd2; o_fd[2]  = fd4;
        o_dat[0] = {3'b000, do1}; o_dat[1] = {2'b00, do2}; o_dat[2] = do4;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            q[i].delete();
            hist[i].delete();
            for (int k = 0; k < 9; k++) hist[i].push_back(0);
        end
    endtask

    function automatic bit m_ready(int i);
        return rst_n && out_en && (q[i].size() <= 1);
    endfunction

    // One clock: apply inputs, record pre-edge ready, advance model, sample.
    task automatic cycle(input bit oe, input bit ven, input logic [7:0] w, input logic [3:0] ds);
        bit acc[3];
        out_en = oe; data_en_in = ven; word = w; dly_sel = ds;
        #1;
        sample(p_rdy);
        for (int i = 0; i < 3; i++) begin
            exp_pr[i] = m_ready(i);
            acc[i]    = ven && exp_pr[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            int wm;
            int nb;
            wm = int'(w) & ((1 << W[i]) - 1);
            nb = W[i] / L[i];
            if (q[i].size() > 0) void'(q[i].pop_front());
            if (acc[i]) begin
                for (int k = 0; k < nb; k++) begin
                    int b;
                    b = (wm >> (W[i] - (k + 1) * L[i])) & ((1 << L[i]) - 1);
                    q[i].push_back(b | ((k == nb - 1) ? 256 : 0));
                end
            end
            hist[i].push_front((q[i].size() > 0) ? 1 : 0);
            void'(hist[i].pop_back());
        end
        sample(o_rdy);
    endtask

    task automatic idle(input int n, input logic [3:0] ds);
        for (int c = 0; c < n; c++) cycle(1'b1, 1'b0, 8'h00, ds);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_en = 1'b1; data_en_in = 1'b1; word = 8'hFF; dly_sel = 4'd0;
        #1;
        sample(o_rdy);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({o_rdy[i], o_en[i], o_dly[i], o_fd[i], o_dat[i]} !== 8'h00) begin
                bad++;
                $display("FAIL reset_outputs dut%0d: got rdy/en/dly/fd/dat=%b%b%b%b/%h want all 0",
                         i, o_rdy[i], o_en[i], o_dly[i], o_fd[i], o_dat[i]);
            end
        end
        @(posedge clk);
        #1;
        sample(o_rdy);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({o_rdy[i], o_en[i], o_dat[i]} !== 6'h00) begin
                bad++;
                $display("FAIL reset_held dut%0d: got rdy=%b en=%b dat=%h want 0", i, o_rdy[i], o_en[i], o_dat[i]);
            end
        end
        rst_n = 1'b1; out_en = 1'b0; data_en_in = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        logic [7:0] seq;
        seq = 8'hA5;
        idle(12, 4'd0);
        cycle(1'b1, 1'b1, seq, 4'd0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cycle(1'b1, 1'b0, 8'h00, 4'd0);
            total++;
            if (en1 !== 1'b1 || do1 !== seq[7-k] || fd1 !== (k == 7) || r1 !== (k == 7)) begin
                bad++;
                $display("FAIL single_beat%0d: got en=%b dat=%b fd=%b rdy=%b want en=1 dat=%b fd=%b rdy=%b",
                         k, en1, do1, fd1, r1, seq[7-k], (k == 7), (k == 7));
            end
        end
        cycle(1'b1, 1'b0, 8'h00, 4'd0);
        total++;
        if (en1 !== 1'b0 || do1 !== 1'b0 || fd1 !== 1'b0) begin
            bad++;
            $display("FAIL single_after: got en=%b dat=%b fd=%b want 0", en1, do1, fd1);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] seq;
        idle(12, 4'd0);
        cycle(1'b1, 1'b1, 8'hA5, 4'd0);
        cycle(1'b1, 1'b0, 8'h00, 4'd0);
        cycle(1'b1, 1'b0, 8'h00, 4'd0);
        rst_n = 1'b0;
        #1;
        total++;
        if ({r1, en1, dl1, fd1, do1} !== 5'b0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got rdy/en/dly/fd/dat=%b%b%b%b%b want 00000", r1, en1, dl1, fd1, do1);
        end
        model_reset();
        rst_n = 1'b1; out_en = 1'b1;
        #1;
        total++;
        if (r1 !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_ready_oe1: got %b want 1", r1);
        end
        out_en = 1'b0;
        #1;
        total++;
        if (r1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_ready_oe0: got %b want 0", r1);
        end
        seq = 8'h3C;
        cycle(1'b1, 1'b1, seq, 4'd0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cycle(1'b1, 1'b0, 8'h00, 4'd0);
            total++;
            if (en1 !== 1'b1 || do1 !== seq[7-k]) begin
                bad++;
                $display("FAIL reset_mid_next_beat%0d: got en=%b dat=%b want en=1 dat=%b", k, en1, do1, seq[7-k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_b[8] = '{3, 2, 1, 0, 0, 1, 2, 3};
        idle(12, 4'd0);
        for (int c = 1; c <= 8; c++) begin
            if (c == 1)      cycle(1'b1, 1'b1, 8'hE4, 4'd0);
            else if (c <= 5) cycle(1'b1, 1'b1, 8'h1B, 4'd0);
            else             cycle(1'b1, 1'b0, 8'h00, 4'd0);
            total++;
            if (en2 !== 1'b1 || int'(do2) != exp_b[c-1] || fd2 !== (c == 4 || c == 8)) begin
                bad++;
                $display("FAIL b2b_cycle%0d: got en=%b dat=%0d fd=%b want en=1 dat=%0d fd=%b",
                         c, en2, do2, fd2, exp_b[c-1], (c == 4 || c == 8));
            end
        end
        cycle(1'b1, 1'b0, 8'h00, 4'd0);
        total++;
        if (en2 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: got en=%b want 0", en2);
        end
    endtask

    task automatic test_oe_drop();
        logic [7:0] seq;
        seq = 8'h96;
        idle(12, 4'd0);
        for (int c = 1; c <= 14; c++) begin
            if (c == 1) cycle(1'b1, 1'b1, seq, 4'd0);
            else        cycle(1'b0, 1'b1, 8'h5A, 4'd0);
            total++;
            if (c <= 8) begin
                if (en1 !== 1'b1 || do1 !== seq[8-c] || fd1 !== (c == 8)) begin
                    bad++;
                    $display("FAIL oe_drop_cycle%0d: got en=%b dat=%b fd=%b want en=1 dat=%b fd=%b",
                             c, en1, do1, fd1, seq[8-c], (c == 8));
                end
            end else if (en1 !== 1'b0 || fd1 !== 1'b0 || r1 !== 1'b0) begin
                bad++;
                $display("FAIL oe_drop_idle%0d: got en=%b fd=%b rdy=%b want 0", c, en1, fd1, r1);
            end
        end
    endtask

    task automatic test_delay();
        int sels[4] = '{0, 3, 8, 15};
        for (int s = 0; s < 4; s++) begin
            int d;
            int highs;
            logic [3:0] ds;
            ds = 4'(sels[s]);
            d = (sels[s] > 8) ? 8 : sels[s];
            highs = 0;
            idle(12, ds);
            for (int t = 1; t <= 15; t++) begin
                if (t == 1) cycle(1'b1, 1'b1, 8'h5A, ds);
                else        cycle(1'b1, 1'b0, 8'h00, ds);
                if (dl2 === 1'b1) highs++;
                total++;
                if (en2 !== (t <= 4) || dl2 !== (t >= 1 + d && t <= 4 + d)) begin
                    bad++;
                    $display("FAIL delay_sel%0d_t%0d: got en=%b dly=%b want en=%b dly=%b",
                             sels[s], t, en2, dl2, (t <= 4), (t >= 1 + d && t <= 4 + d));
                end
            end
            total++;
            if (highs != 4) begin
                bad++;
                $display("FAIL delay_width_sel%0d: got %0d cycles want 4", sels[s], highs);
            end
        end
    endtask

    task automatic test_beats1();
        idle(12, 4'd0);
        for (int v = 1; v <= 5; v++) begin
            cycle(1'b1, 1'b1, 8'(v), 4'd0);
            total++;
            if (en4 !== 1'b1 || fd4 !== 1'b1 || int'(do4) != v) begin
                bad++;
                $display("FAIL beats1_word%0d: got en=%b fd=%b dat=%0d want 1 1 %0d", v, en4, fd4, do4, v);
            end
        end
        cycle(1'b1, 1'b0, 8'h00, 4'd0);
        total++;
        if (en4 !== 1'b0 || fd4 !== 1'b0 || do4 !== 4'h0) begin
            bad++;
            $display("FAIL beats1_end: got en=%b fd=%b dat=%h want 0", en4, fd4, do4);
        end
    endtask

    task automatic test_random();
        logic [3:0] ds;
        ds = 4'd0;
        for (int n = 0; n < 800; n++) begin
            if (n % 50 == 0) ds = 4'($urandom_range(0, 15));
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0), 8'($urandom), ds);
            for (int i = 0; i < 3; i++) begin
                bit         e_en;
                bit         e_fd;
                bit         e_dly;
                logic [3:0] e_dat;
                int         d;
                e_en  = (q[i].size() > 0);
                e_dat = e_en ? 4'(q[i][0] & 15) : 4'h0;
                e_fd  = e_en && (q[i][0] >= 256);
                d     = (ds > 4'd8) ? 8 : int'(ds);
                e_dly = (hist[i][d] != 0);
                total++;
                if (p_rdy[i] !== exp_pr[i] || o_en[i] !== e_en || o_dat[i] !== e_dat ||
                    o_fd[i] !== e_fd || o_dly[i] !== e_dly) begin
                    bad++;
                    $display("FAIL random_n%0d_dut%0d: got rdy=%b en=%b dat=%h fd=%b dly=%b want rdy=%b en=%b dat=%h fd=%b dly=%b",
                             n, i, p_rdy[i], o_en[i], o_dat[i], o_fd[i], o_dly[i],
                             exp_pr[i], e_en, e_dat, e_fd, e_dly);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; out_en = 1'b0; data_en_in = 1'b0; word = 8'h00; dly_sel = 4'd0;
        model_reset();
        #2;
        test_reset();
        test_single();
        test_reset_mid();
        test_back_to_back();
        test_oe_drop();
        test_delay();
        test_beats1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
